toggle_debounce: RTL

//   Conditions a raw, bouncy, asynchronous push-button into a clean one-cycle

---
 rtl/toggle_debounce.sv | 130 +++++++++++++
 1 files changed

// File: rtl/toggle_debounce.sv
// Push-button conditioner: synchronizer, debounce FSM and a one-cycle toggle pulse per accepted press.
// Define TOGGLE_REPEAT_EN to add auto-repeat pulses while the button is held.
module toggle_debounce #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned DB_CYCLES     = 16,
   parameter int unsigned REPEAT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic t_pulse,
   output logic btn_level,
   output logic busy
);

   localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("toggle_debounce: SYNC_STAGES must be >= 2");
   end
   if (DB_CYCLES < 2) begin : g_bad_db
      $error("toggle_debounce: DB_CYCLES must be >= 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_rep
      $error("toggle_debounce: REPEAT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   state_t                 r_state;
   logic [CW-1:0]          r_cnt;

   assign w_s = r_sync[SYNC_STAGES-1];

`ifdef TOGGLE_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_ONE  = RW'(1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] r_rep;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE_LO;
         r_cnt     <= '0;
         t_pulse   <= 1'b0;
         btn_level <= 1'b0;
         busy      <= 1'b0;
`ifdef TOGGLE_REPEAT_EN
         r_rep     <= '0;
`endif
      end else begin
         t_pulse <= 1'b0;
         case (r_state)
            IDLE_LO: begin
               if (w_s) begin
                  r_state <= CHK_HI;
                  r_cnt   <= CNT_ONE;
                  busy    <= 1'b1;
               end
            end
            CHK_HI: begin
               if (!w_s) begin
                  r_state <= IDLE_LO;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= IDLE_HI;
                  r_cnt     <= '0;
                  busy      <= 1'b0;
                  btn_level <= 1'b1;
                  t_pulse   <= 1'b1;
`ifdef TOGGLE_REPEAT_EN
                  r_rep     <= '0;
`endif
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            IDLE_HI: begin
               // repeat counter only advances on cycles that stay in IDLE_HI
               if (!w_s) begin
                  r_state <= CHK_LO;
                  r_cnt   <= CNT_ONE;
                  busy    <= 1'b1;
`ifdef TOGGLE_REPEAT_EN
               end else if (r_rep == REP_LAST) begin
                  r_rep   <= '0;
                  t_pulse <= 1'b1;
               end else begin
                  r_rep <= r_rep + REP_ONE;
`endif
               end
            end
            CHK_LO: begin
               if (w_s) begin
                  r_state <= IDLE_HI;
                  r_cnt   <= '0;
                  busy    <= 1'b0;
`ifdef TOGGLE_REPEAT_EN
                  r_rep   <= '0;
`endif
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= IDLE_LO;
                  r_cnt     <= '0;
                  busy      <= 1'b0;
                  btn_level <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE_LO;
               r_cnt   <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
